// File: rtl/hazard_scoreboard_pkg.sv
// Shared constants for the register-readiness hazard scoreboard.
// Default latencies describe the baseline 5-stage pipeline with branches resolved in ID.
package hazard_scoreboard_pkg;
    localparam int REG_ZERO         = 0;
    localparam int DEF_ALU_LAT      = 0;
    localparam int DEF_LOAD_LAT     = 1;
    localparam int DEF_BRANCH_EXTRA = 1;
endpackage

// File: rtl/hazard_cnt_entry.sv
// One register's readiness countdown: reload on issue, otherwise count down to zero.
// gt reports whether the remaining count still exceeds the consumer's threshold.
module hazard_cnt_entry #(
    parameter int CNT_W = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic [CNT_W-1:0] thr,
    output logic             gt
);

    logic [CNT_W-1:0] cnt;

    // A new producer overrides the decrement so write-after-write keeps the newer latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign gt = (cnt > thr);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: stalls consumers until producer results are forwardable,
// flushes IF/ID on taken branches and keeps a saturating count of stall cycles.
module hazard_scoreboard
    import hazard_scoreboard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int ALU_LAT      = DEF_ALU_LAT,
    parameter int LOAD_LAT     = DEF_LOAD_LAT,
    parameter int BRANCH_EXTRA = DEF_BRANCH_EXTRA,
    parameter int CNT_W        = 3,
    parameter int STAT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic              id_is_branch,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              stall,
    output logic [STAT_W-1:0] stall_cycles
);

    localparam int NREG = 2 ** REG_AW;
    localparam logic [CNT_W-1:0] ALU_VAL  = CNT_W'(ALU_LAT + BRANCH_EXTRA);
    localparam logic [CNT_W-1:0] LOAD_VAL = CNT_W'(LOAD_LAT + BRANCH_EXTRA);
    localparam logic [CNT_W-1:0] THR_ALU  = CNT_W'(BRANCH_EXTRA);
    localparam logic [REG_AW-1:0] R0      = REG_AW'(REG_ZERO);

    logic [NREG-1:0]  gt;
    logic [CNT_W-1:0] thr;
    logic [CNT_W-1:0] wr_val;
    logic             haz_rs;
    logic             haz_rt;
    logic             issue;
    logic             wr_en;

    // Branches compare in ID, so they need the value one stage earlier than an ALU consumer.
    assign thr    = id_is_branch ? '0 : THR_ALU;
    assign wr_val = id_mem_read ? LOAD_VAL : ALU_VAL;

    assign gt[0] = 1'b0;

    genvar r;
    for (r = 1; r < NREG; r++) begin : g_entry
        hazard_cnt_entry #(
            .CNT_W(CNT_W)
        ) u_entry (
            .clk     (clk),
            .rst_n   (rst_n),
            .load    (wr_en && (id_dst == REG_AW'(r))),
            .load_val(wr_val),
            .thr     (thr),
            .gt      (gt[r])
        );
    end

    assign haz_rs = id_valid & id_uses_rs & (id_rs != R0) & gt[id_rs];
    assign haz_rt = id_valid & id_uses_rt & (id_rt != R0) & gt[id_rt];

    assign stall        = haz_rs | haz_rt;
    assign pc_write     = ~stall;
    assign if_id_write  = ~stall;
    assign id_ex_bubble = stall;
    assign if_id_flush  = branch_taken & id_valid & ~stall;

    // Sources were checked against the old counts above; the producer's own entry reloads after.
    assign issue = id_valid & ~stall;
    assign wr_en = issue & id_reg_write & (id_dst != R0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (stall && (stall_cycles != {STAT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: instance 0 uses default latencies, instance 1 uses
// LOAD_LAT=3 with a 4-bit stall counter; a timestamp model predicts every output.
module tb_hazard_scoreboard;

    localparam int AW      = 5;
    localparam int NREG    = 32;
    localparam int ALU_LAT = 0;
    localparam int BE      = 1;

    logic clk = 1'b0;
    logic rst_n;

    logic       valid [2];
    logic [4:0] rs    [2];
    logic [4:0] rt    [2];
    logic       urs   [2];
    logic       urt   [2];
    logic       br    [2];
    logic       rw    [2];
    logic       mr    [2];
    logic [4:0] dst   [2];
    logic       tk    [2];

    logic pcw [2];
    logic ifw [2];
    logic bub [2];
    logic fl  [2];
    logic stl [2];
    logic [15:0] sc_a;
    logic [3:0]  sc_b;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    hazard_scoreboard dut_a (
        .clk(clk), .rst_n(rst_n), .id_valid(valid[0]), .id_rs(rs[0]), .id_rt(rt[0]),
        .id_uses_rs(urs[0]), .id_uses_rt(urt[0]), .id_is_branch(br[0]),
        .id_reg_write(rw[0]), .id_mem_read(mr[0]), .id_dst(dst[0]), .branch_taken(tk[0]),
        .pc_write(pcw[0]), .if_id_write(ifw[0]), .id_ex_bubble(bub[0]),
        .if_id_flush(fl[0]), .stall(stl[0]), .stall_cycles(sc_a)
    );

    hazard_scoreboard #(.LOAD_LAT(3), .STAT_W(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .id_valid(valid[1]), .id_rs(rs[1]), .id_rt(rt[1]),
        .id_uses_rs(urs[1]), .id_uses_rt(urt[1]), .id_is_branch(br[1]),
        .id_reg_write(rw[1]), .id_mem_read(mr[1]), .id_dst(dst[1]), .branch_taken(tk[1]),
        .pc_write(pcw[1]), .if_id_write(ifw[1]), .id_ex_bubble(bub[1]),
        .if_id_flush(fl[1]), .stall(stl[1]), .stall_cycles(sc_b)
    );

    // Model: avail[i][r] is the first cycle index at which a non-branch consumer of r may sit in ID.
    int avail [2][NREG];
    int scnt  [2];
    int cyc = 10;

    function automatic int load_lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int stat_max(input int i);
        return (i == 0) ? 65535 : 15;
    endfunction

    function automatic logic model_stall(input int i);
        int extra;
        logic h;
        h = 1'b0;
        extra = br[i] ? BE : 0;
        if (valid[i]) begin
            if (urs[i] && rs[i] != 0 && cyc < avail[i][rs[i]] + extra) h = 1'b1;
            if (urt[i] && rt[i] != 0 && cyc < avail[i][rt[i]] + extra) h = 1'b1;
        end
        return h;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 2; i++) begin
                scnt[i] <= 0;
                for (int r = 0; r < NREG; r++) avail[i][r] <= 0;
            end
        end else begin
            for (int i = 0; i < 2; i++) begin
                if (model_stall(i)) begin
                    if (scnt[i] < stat_max(i)) scnt[i] <= scnt[i] + 1;
                end else if (valid[i] && rw[i] && dst[i] != 0) begin
                    avail[i][dst[i]] <= cyc + 1 + (mr[i] ? load_lat(i) : ALU_LAT);
                end
            end
            cyc <= cyc + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            logic es;
            es = model_stall(i);
            chk($sformatf("stall_%0d", i), 32'(stl[i]), 32'(es));
            chk($sformatf("bubble_%0d", i), 32'(bub[i]), 32'(es));
            chk($sformatf("pc_write_%0d", i), 32'(pcw[i]), 32'(!es));
            chk($sformatf("if_id_write_%0d", i), 32'(ifw[i]), 32'(!es));
            chk($sformatf("flush_%0d", i), 32'(fl[i]), 32'(tk[i] & valid[i] & !es));
            chk($sformatf("stat_%0d", i), (i == 0) ? 32'(sc_a) : 32'(sc_b), 32'(scnt[i]));
        end
    end

    task automatic clear(input int i);
        valid[i] = 0; rs[i] = 0; rt[i] = 0; urs[i] = 0; urt[i] = 0;
        br[i] = 0; rw[i] = 0; mr[i] = 0; dst[i] = 0; tk[i] = 0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0;
        @(posedge clk);
        #1;
        rst_n = 1;
    endtask

    // Holds one instruction in ID until it issues; reports stall cycles and flush behaviour.
    task automatic send(input int i, input logic [4:0] s1, input logic [4:0] s2,
                        input logic u1, input logic u2, input logic b, input logic w,
                        input logic m, input logic [4:0] d, input logic t,
                        output int stalls, output logic fl_stall, output logic fl_issue);
        logic done;
        stalls = 0; fl_stall = 0; fl_issue = 0; done = 0;
        valid[i] = 1; rs[i] = s1; rt[i] = s2; urs[i] = u1; urt[i] = u2;
        br[i] = b; rw[i] = w; mr[i] = m; dst[i] = d; tk[i] = t;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            #1;
            if (stl[i]) begin
                stalls++;
                if (fl[i]) fl_stall = 1;
            end else begin
                fl_issue = fl[i];
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        clear(i);
        chk("issue_bound", 32'(done), 32'd1);
    endtask

    int   st;
    logic fs, fi;

    initial begin
        rst_n = 0;
        clear(0);
        clear(1);
        idle(2);
        chk("rst_pc_write", 32'(pcw[0]), 32'd1);
        chk("rst_bubble", 32'(bub[0]), 32'd0);
        chk("rst_stat", 32'(sc_a), 32'd0);
        rst_n = 1;

        // load -> ALU
        send(0, 0, 0, 0, 0, 0, 1, 1, 3, 0, st, fs, fi);
        send(0, 2, 3, 1, 1, 0, 1, 0, 1, 0, st, fs, fi);
        chk("lu_stalls", 32'(st), 32'd1);
        chk("lu_stat", 32'(sc_a), 32'd1);

        // load -> taken branch
        do_reset();
        send(0, 0, 0, 0, 0, 0, 1, 1, 5, 0, st, fs, fi);
        send(0, 5, 6, 1, 1, 1, 0, 0, 0, 1, st, fs, fi);
        chk("lb_stalls", 32'(st), 32'd2);
        chk("lb_flush_stalled", 32'(fs), 32'd0);
        chk("lb_flush_issue", 32'(fi), 32'd1);

        // ALU -> branch, ALU -> ALU
        do_reset();
        send(0, 1, 2, 1, 1, 0, 1, 0, 4, 0, st, fs, fi);
        send(0, 4, 0, 1, 1, 1, 0, 0, 0, 0, st, fs, fi);
        chk("ab_stalls", 32'(st), 32'd1);
        idle(3);
        send(0, 1, 2, 1, 1, 0, 1, 0, 4, 0, st, fs, fi);
        send(0, 4, 4, 1, 1, 0, 1, 0, 7, 0, st, fs, fi);
        chk("aa_stalls", 32'(st), 32'd0);

        // register zero and unused source
        send(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, st, fs, fi);
        send(0, 0, 0, 1, 1, 0, 1, 0, 1, 0, st, fs, fi);
        chk("r0_stalls", 32'(st), 32'd0);
        send(0, 0, 0, 0, 0, 0, 1, 1, 3, 0, st, fs, fi);
        send(0, 1, 3, 1, 0, 0, 1, 0, 2, 0, st, fs, fi);
        chk("unused_rt_stalls", 32'(st), 32'd0);

        // LOAD_LAT = 3 instance, then write-after-write
        do_reset();
        send(1, 0, 0, 0, 0, 0, 1, 1, 9, 0, st, fs, fi);
        send(1, 9, 9, 1, 1, 0, 1, 0, 10, 0, st, fs, fi);
        chk("ll3_stalls", 32'(st), 32'd3);
        idle(6);
        send(1, 0, 0, 0, 0, 0, 1, 1, 9, 0, st, fs, fi);
        send(1, 1, 2, 1, 1, 0, 1, 0, 9, 0, st, fs, fi);
        chk("waw_issue_stalls", 32'(st), 32'd0);
        send(1, 9, 0, 1, 0, 0, 1, 0, 11, 0, st, fs, fi);
        chk("waw_consumer_stalls", 32'(st), 32'd0);

        // reset in the middle of a load -> branch stall
        do_reset();
        send(0, 0, 0, 0, 0, 0, 1, 1, 5, 0, st, fs, fi);
        valid[0] = 1; rs[0] = 5; rt[0] = 6; urs[0] = 1; urt[0] = 1; br[0] = 1; tk[0] = 1;
        #1;
        chk("mr_stall_c1", 32'(stl[0]), 32'd1);
        @(posedge clk);
        #1;
        chk("mr_stall_c2", 32'(stl[0]), 32'd1);
        chk("mr_stat_pre", 32'(sc_a), 32'd1);
        rst_n = 0;
        #1;
        chk("mr_stall_rst", 32'(stl[0]), 32'd0);
        chk("mr_pc_write_rst", 32'(pcw[0]), 32'd1);
        chk("mr_stat_rst", 32'(sc_a), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1;
        #1;
        chk("mr_stall_release", 32'(stl[0]), 32'd0);
        @(posedge clk);
        #1;
        clear(0);

        // saturation of the 4-bit counter on instance 1
        do_reset();
        for (int k = 0; k < 5; k++) send(1, 3, 0, 1, 0, 1, 1, 1, 3, 0, st, fs, fi);
        chk("sat_last_stalls", 32'(st), 32'd4);
        chk("sat_stat", 32'(sc_b), 32'd15);
        idle(2);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
